// File: rtl/vls_multi_lane.sv
// Multi-lane vector load/store stage: per-lane request FIFO, address generation, scratchpad issue and load write-back.
// Optional VLS_ALIGN_CHECK_EN: misaligned requests are dropped at pop and flagged on err_misalign.

module vls_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // The extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

module vls_multi_lane #(
  parameter int NUM_LANES  = 2,
  parameter int ADDR_W     = 16,
  parameter int IMM_W      = 8,
  parameter int VREG_W     = 4,
  parameter int LINE_W     = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int ALIGN_LOG2 = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_LANES-1:0]          req_valid,
  output logic [NUM_LANES-1:0]          req_ready,
  input  logic [NUM_LANES-1:0]          req_store,
  input  logic [NUM_LANES*VREG_W-1:0]   req_vd,
  input  logic [NUM_LANES*ADDR_W-1:0]   req_base,
  input  logic [NUM_LANES*IMM_W-1:0]    req_imm,
  output logic [NUM_LANES-1:0]          sp_req_valid,
  input  logic [NUM_LANES-1:0]          sp_req_ready,
  output logic [NUM_LANES-1:0]          sp_req_store,
  output logic [NUM_LANES*VREG_W-1:0]   sp_req_vd,
  output logic [NUM_LANES*ADDR_W-1:0]   sp_req_addr,
  input  logic [NUM_LANES-1:0]          sp_resp_valid,
  input  logic [NUM_LANES*LINE_W-1:0]   sp_resp_data,
  output logic [NUM_LANES-1:0]          wb_valid,
  input  logic [NUM_LANES-1:0]          wb_ready,
  output logic [NUM_LANES*VREG_W-1:0]   wb_vd,
  output logic [NUM_LANES*LINE_W-1:0]   wb_data,
`ifdef VLS_ALIGN_CHECK_EN
  output logic [NUM_LANES-1:0]          err_misalign,
`endif
  output logic                          busy
);
  localparam int EW = 1 + VREG_W + ADDR_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_LOG2) - 1);
`ifdef VLS_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  logic [NUM_LANES-1:0] lane_busy;
  assign busy = |lane_busy;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] enq_addr;
    logic [EW-1:0]     enq_entry;
    logic [EW-1:0]     head;
    logic              full;
    logic              empty;
    logic              pop;
    logic              head_store;
    logic [VREG_W-1:0] head_vd;
    logic [ADDR_W-1:0] head_addr;
    logic              misalign;

    state_t            state;
    logic              iss_vld;
    logic              iss_store;
    logic [VREG_W-1:0] iss_vd;
    logic [ADDR_W-1:0] iss_addr;
    logic              wb_vld;
    logic [VREG_W-1:0] wb_vd_q;
    logic [LINE_W-1:0] wb_dat_q;

    // Address is resolved at enqueue so the FIFO carries only the final value.
    assign imm       = req_imm[i*IMM_W +: IMM_W];
    assign enq_addr  = req_base[i*ADDR_W +: ADDR_W] + {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign enq_entry = {req_store[i], req_vd[i*VREG_W +: VREG_W], enq_addr};
    assign {head_store, head_vd, head_addr} = head;
    assign misalign  = |(head_addr & ALIGN_MASK);
    assign pop       = (state == S_IDLE) && !empty;

    vls_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (req_valid[i]),
      .wdata (enq_entry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
    );

`ifdef VLS_ALIGN_CHECK_EN
    logic err_q;
    assign err_misalign[i] = err_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) err_q <= 1'b0;
      else     err_q <= pop && misalign;
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state     <= S_IDLE;
        iss_vld   <= 1'b0;
        iss_store <= 1'b0;
        iss_vd    <= '0;
        iss_addr  <= '0;
        wb_vld    <= 1'b0;
        wb_vd_q   <= '0;
        wb_dat_q  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!empty && !(ALIGN_CHK && misalign)) begin
              iss_vld   <= 1'b1;
              iss_store <= head_store;
              iss_vd    <= head_vd;
              iss_addr  <= head_addr;
              state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (sp_req_ready[i]) begin
              iss_vld <= 1'b0;
              state   <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (sp_resp_valid[i]) begin
              if (iss_store) begin
                state <= S_IDLE;
              end else begin
                wb_vld   <= 1'b1;
                wb_vd_q  <= iss_vd;
                wb_dat_q <= sp_resp_data[i*LINE_W +: LINE_W];
                state    <= S_WB;
              end
            end
          end
          S_WB: begin
            if (wb_ready[i]) begin
              wb_vld <= 1'b0;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    assign req_ready[i]                      = !full;
    assign sp_req_valid[i]                   = iss_vld;
    assign sp_req_store[i]                   = iss_store;
    assign sp_req_vd[i*VREG_W +: VREG_W]     = iss_vd;
    assign sp_req_addr[i*ADDR_W +: ADDR_W]   = iss_addr;
    assign wb_valid[i]                       = wb_vld;
    assign wb_vd[i*VREG_W +: VREG_W]         = wb_vd_q;
    assign wb_data[i*LINE_W +: LINE_W]       = wb_dat_q;
    assign lane_busy[i]                      = !empty || (state != S_IDLE);
  end
endmodule

// File: tb/tb_vls_multi_lane.sv
// Directed bench for vls_multi_lane (2 lanes): latency, wrap, FIFO fill/order, lane independence, reset abort, alignment.

module tb_vls_multi_lane;
  localparam int NL = 2;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int VW = 4;
  localparam int LW = 1024;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NL-1:0]    req_valid;
  logic [NL-1:0]    req_ready;
  logic [NL-1:0]    req_store;
  logic [NL*VW-1:0] req_vd;
  logic [NL*AW-1:0] req_base;
  logic [NL*IW-1:0] req_imm;
  logic [NL-1:0]    sp_req_valid;
  logic [NL-1:0]    sp_req_ready;
  logic [NL-1:0]    sp_req_store;
  logic [NL*VW-1:0] sp_req_vd;
  logic [NL*AW-1:0] sp_req_addr;
  logic [NL-1:0]    sp_resp_valid;
  logic [NL*LW-1:0] sp_resp_data;
  logic [NL-1:0]    wb_valid;
  logic [NL-1:0]    wb_ready;
  logic [NL*VW-1:0] wb_vd;
  logic [NL*LW-1:0] wb_data;
`ifdef VLS_ALIGN_CHECK_EN
  logic [NL-1:0]    err_misalign;
`endif
  logic             busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  vls_multi_lane u_dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_store     (req_store),
    .req_vd        (req_vd),
    .req_base      (req_base),
    .req_imm       (req_imm),
    .sp_req_valid  (sp_req_valid),
    .sp_req_ready  (sp_req_ready),
    .sp_req_store  (sp_req_store),
    .sp_req_vd     (sp_req_vd),
    .sp_req_addr   (sp_req_addr),
    .sp_resp_valid (sp_resp_valid),
    .sp_resp_data  (sp_resp_data),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_vd         (wb_vd),
    .wb_data       (wb_data),
`ifdef VLS_ALIGN_CHECK_EN
    .err_misalign  (err_misalign),
`endif
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int l, input logic v, input logic st, input logic [VW-1:0] vd,
                         input logic [AW-1:0] base, input logic [IW-1:0] imm);
    req_valid[l]          = v;
    req_store[l]          = st;
    req_vd[l*VW +: VW]    = vd;
    req_base[l*AW +: AW]  = base;
    req_imm[l*IW +: IW]   = imm;
  endtask

  function automatic logic [LW-1:0] pat(input logic [15:0] seed);
    logic [LW-1:0] r;
    for (int j = 0; j < 32; j++) r[j*32 +: 32] = {seed, j[15:0]};
    return r;
  endfunction

  logic [LW-1:0] p0;
  logic [LW-1:0] p1;
  int            n_iss;

  initial begin
    RST = 1'b1;
    req_valid = '0; req_store = '0; req_vd = '0; req_base = '0; req_imm = '0;
    sp_req_ready = '0; sp_resp_valid = '0; sp_resp_data = '0; wb_ready = '0;
    #3;
    chk("rst_req_ready", req_ready, 2'b11);
    chk("rst_sp_req_valid", sp_req_valid, 2'b00);
    chk("rst_wb_valid", wb_valid, 2'b00);
    chk("rst_busy", busy, 1'b0);
`ifdef VLS_ALIGN_CHECK_EN
    chk("rst_err", err_misalign, 2'b00);
`endif
    tick();
    RST = 1'b0;
    sp_req_ready = 2'b11;
    wb_ready = 2'b11;

    // Lane 0 load: 0x0100 + (-4) = 0x00FC, wb_valid 3 edges after the enqueue edge
    p0 = pat(16'hC0DE);
    set_req(0, 1'b1, 1'b0, 4'd3, 16'h0100, 8'hFC);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_wb_e1", wb_valid[0], 1'b0);
    tick();
    chk("t1_sp_valid", sp_req_valid[0], 1'b1);
    chk("t1_sp_addr", sp_req_addr[15:0], 16'h00FC);
    chk("t1_sp_store", sp_req_store[0], 1'b0);
    chk("t1_sp_vd", sp_req_vd[3:0], 4'd3);
    tick();
    chk("t1_sp_valid_drop", sp_req_valid[0], 1'b0);
    chk("t1_wb_e3", wb_valid[0], 1'b0);
    sp_resp_valid[0] = 1'b1;
    sp_resp_data[LW-1:0] = p0;
    tick();
    sp_resp_valid[0] = 1'b0;
    chk("t1_wb_valid", wb_valid[0], 1'b1);
    chk("t1_wb_vd", wb_vd[3:0], 4'd3);
    chk("t1_wb_data", wb_data[LW-1:0], p0);
    tick();
    chk("t1_wb_done", wb_valid[0], 1'b0);
    chk("t1_idle", busy, 1'b0);

    // Lane 1 store: 0xFFF0 + 0x20 wraps to 0x0010, no write-back
    set_req(1, 1'b1, 1'b1, 4'd5, 16'hFFF0, 8'h20);
    tick();
    set_req(1, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    tick();
    chk("t2_sp_valid", sp_req_valid[1], 1'b1);
    chk("t2_sp_addr", sp_req_addr[31:16], 16'h0010);
    chk("t2_sp_store", sp_req_store[1], 1'b1);
    tick();
    sp_resp_valid[1] = 1'b1;
    tick();
    sp_resp_valid[1] = 1'b0;
    chk("t2_no_wb_a", wb_valid[1], 1'b0);
    tick();
    chk("t2_no_wb_b", wb_valid[1], 1'b0);
    chk("t2_idle", busy, 1'b0);

    // Lane 0: five back-to-back stores while the scratchpad stalls
    sp_req_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_rdy%0d", k), req_ready[0], 1'b1);
      set_req(0, 1'b1, 1'b1, 4'(k), 16'h0200 + 16'(k * 16'h40), 8'h00);
      tick();
    end
    chk("t3_full", req_ready[0], 1'b0);
    set_req(0, 1'b1, 1'b1, 4'd7, 16'h0F00, 8'h00);
    tick();
    tick();
    chk("t3_full_hold", req_ready[0], 1'b0);
    set_req(0, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    sp_req_ready[0] = 1'b1;
    sp_resp_valid[0] = 1'b1;
    n_iss = 0;
    for (int c = 0; c < 40; c++) begin
      if (sp_req_valid[0]) begin
        if (n_iss < 5)
          chk($sformatf("t3_order%0d", n_iss), sp_req_addr[15:0], 16'h0200 + 16'(n_iss * 16'h40));
        n_iss++;
      end
      tick();
    end
    sp_resp_valid[0] = 1'b0;
    chk("t3_issue_count", n_iss, 5);
    chk("t3_idle", busy, 1'b0);

    // Both lanes load; lane 1 write-back stalled for 10 cycles
    p0 = pat(16'hAAAA);
    p1 = pat(16'h5555);
    wb_ready = 2'b01;
    set_req(0, 1'b1, 1'b0, 4'd1, 16'h0300, 8'h00);
    set_req(1, 1'b1, 1'b0, 4'd2, 16'h0400, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    sp_resp_valid = 2'b11;
    sp_resp_data = {p1, p0};
    tick();
    tick();
    tick();
    chk("t4_wb_both", wb_valid, 2'b11);
    chk("t4_l0_data", wb_data[LW-1:0], p0);
    chk("t4_l0_vd", wb_vd[3:0], 4'd1);
    sp_resp_valid = 2'b00;
    sp_resp_data = {~p1, ~p0};
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t4_l0_done%0d", c), wb_valid[0], 1'b0);
      chk($sformatf("t4_l1_vld%0d", c), wb_valid[1], 1'b1);
      chk($sformatf("t4_l1_data%0d", c), wb_data[2*LW-1:LW], p1);
      chk($sformatf("t4_l1_vd%0d", c), wb_vd[7:4], 4'd2);
    end
    wb_ready = 2'b11;
    tick();
    chk("t4_l1_done", wb_valid[1], 1'b0);
    chk("t4_idle", busy, 1'b0);

    // Reset while lane 0 waits for a response and lane 1 sits in ISSUE
    sp_req_ready[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 4'd6, 16'h0500, 8'h00);
    set_req(1, 1'b1, 1'b0, 4'd6, 16'h0600, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    set_req(1, 1'b1, 1'b0, 4'd8, 16'h0640, 8'h00);
    tick();
    set_req(1, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    tick();
    chk("t5_l1_stuck", sp_req_valid[1], 1'b1);
    RST = 1'b1;
    #1;
    chk("t5_rst_rdy", req_ready, 2'b11);
    chk("t5_rst_sp_valid", sp_req_valid, 2'b00);
    chk("t5_rst_addr", sp_req_addr, 32'h0);
    chk("t5_rst_busy", busy, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sp_req_ready = 2'b11;
    sp_resp_valid = 2'b11;
    tick();
    tick();
    sp_resp_valid = 2'b00;
    chk("t5_no_wb", wb_valid, 2'b00);
    chk("t5_no_issue", sp_req_valid, 2'b00);
    chk("t5_idle", busy, 1'b0);

    // Misaligned address 0x0102
    set_req(0, 1'b1, 1'b0, 4'd9, 16'h0102, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    tick();
`ifdef VLS_ALIGN_CHECK_EN
    chk("t6_err", err_misalign[0], 1'b1);
    chk("t6_no_issue", sp_req_valid[0], 1'b0);
    tick();
    chk("t6_err_pulse", err_misalign[0], 1'b0);
    chk("t6_no_issue_b", sp_req_valid[0], 1'b0);
    chk("t6_dropped", busy, 1'b0);
    set_req(0, 1'b1, 1'b0, 4'd9, 16'h0104, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, 16'h0, 8'h0);
    tick();
    chk("t6_ok_issue", sp_req_valid[0], 1'b1);
    chk("t6_ok_addr", sp_req_addr[15:0], 16'h0104);
    chk("t6_ok_err", err_misalign[0], 1'b0);
`else
    chk("t6_issue", sp_req_valid[0], 1'b1);
    chk("t6_addr", sp_req_addr[15:0], 16'h0102);
`endif
    sp_resp_valid[0] = 1'b1;
    tick();
    tick();
    sp_resp_valid[0] = 1'b0;
    chk("t6_wb", wb_valid[0], 1'b1);
    tick();
    chk("t6_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
